// File: rtl/cc1200_reg_ctrl.sv
// cc1200_reg_ctrl: turns one CC1200 register command into a full CS_n frame
// on the SPI byte engine (header, optional ext address, 0..63 data bytes).
module cc1200_reg_ctrl (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rnw,
    input  logic       cmd_ext,
    input  logic [7:0] cmd_addr,
    input  logic [5:0] cmd_len,
    output logic       wr_req,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic [7:0] status,
    output logic       status_valid,
    output logic       done,
    output logic       busy,
    output logic       spi_start,
    output logic       spi_stop,
    output logic [7:0] spi_dout,
    input  logic       spi_busy,
    input  logic       spi_load_next,
    input  logic [7:0] spi_din
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_XFER,
        S_DRAIN
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic       rnw_q;
    logic       ext_q;
    logic [7:0] addr_q;
    logic [6:0] total_q;
    logic [6:0] sent_q;
    logic       upd_q;
    logic       rdy_q;
    logic [7:0] dout_q;
    logic [7:0] rd_data_q;
    logic       rd_valid_q;
    logic [7:0] status_q;
    logic       status_valid_q;
    logic       done_q;

    logic [5:0] len_eff;
    logic [7:0] hdr;
    logic       accept;
    logic       ln;
    logic       last;
    logic [6:0] data_lo;
    logic       nxt_in_list;
    logic       nxt_data;
    logic       nxt_ext;
    logic [6:0] cap_idx;
    logic       cap_data;
    logic [7:0] nxt_byte;

    always_comb begin
        len_eff     = (cmd_ext && cmd_len == 6'd0) ? 6'd1 : cmd_len;
        hdr         = {cmd_rnw, (len_eff > 6'd1),
                       (cmd_ext ? 6'h2F : cmd_addr[5:0])};
        accept      = cmd_valid & rdy_q;
        ln          = spi_load_next && (state_q == S_XFER);
        last        = (sent_q == total_q);
        data_lo     = 7'd1 + {6'd0, ext_q};
        // sent_q is also the index of the next byte to present
        nxt_in_list = (sent_q < total_q);
        nxt_data    = nxt_in_list && (sent_q >= data_lo);
        nxt_ext     = ext_q && (sent_q == 7'd1);
        cap_idx     = sent_q - 7'd1;
        cap_data    = (cap_idx >= data_lo);
        nxt_byte    = 8'h00;
        if (nxt_ext) begin
            nxt_byte = addr_q;
        end else if (nxt_data && !rnw_q) begin
            nxt_byte = wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_START;
            S_START: state_d = S_XFER;
            S_XFER:  if (ln && last) state_d = S_DRAIN;
            S_DRAIN: if (!spi_busy) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d == S_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rnw_q   <= 1'b0;
            ext_q   <= 1'b0;
            addr_q  <= 8'h00;
            total_q <= 7'd0;
            sent_q  <= 7'd0;
            upd_q   <= 1'b0;
            dout_q  <= 8'h00;
        end else begin
            upd_q <= (state_q == S_START) || ln;
            if (accept) begin
                rnw_q   <= cmd_rnw;
                ext_q   <= cmd_ext;
                addr_q  <= cmd_addr;
                total_q <= 7'd1 + {6'd0, cmd_ext} + {1'b0, len_eff};
                sent_q  <= 7'd1;
                dout_q  <= hdr;
            end else if (upd_q) begin
                dout_q <= nxt_byte;
            end
            if (ln) begin
                sent_q <= sent_q + 7'd1;
            end
        end
    end

    // spi_din is held by the engine until its next byte completes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data_q      <= 8'h00;
            rd_valid_q     <= 1'b0;
            status_q       <= 8'h00;
            status_valid_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            status_valid_q <= ln && (cap_idx == 7'd0);
            rd_valid_q     <= ln && rnw_q && cap_data;
            done_q         <= ln && last;
            if (ln && cap_idx == 7'd0) begin
                status_q <= spi_din;
            end
            if (ln && rnw_q && cap_data) begin
                rd_data_q <= spi_din;
            end
        end
    end

    assign cmd_ready    = rdy_q;
    assign busy         = (state_q != S_IDLE);
    assign spi_start    = (state_q == S_START);
    assign spi_stop     = (state_q == S_XFER) && last;
    assign spi_dout     = dout_q;
    assign wr_req       = upd_q && !rnw_q && nxt_data;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign status       = status_q;
    assign status_valid = status_valid_q;
    assign done         = done_q;

endmodule

// File: tb/tb_cc1200_reg_ctrl.sv
// tb_cc1200_reg_ctrl: directed + random frames against a byte-list model
// of the CC1200 command sequencer, with a simple SPI engine responder.
module tb_cc1200_reg_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rnw = 1'b0;
    logic       cmd_ext = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [5:0] cmd_len = 6'd0;
    logic       wr_req;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [7:0] status;
    logic       status_valid;
    logic       done;
    logic       busy;
    logic       spi_start;
    logic       spi_stop;
    logic [7:0] spi_dout;
    logic       spi_busy;
    logic       spi_load_next;
    logic [7:0] spi_din;

    cc1200_reg_ctrl dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rnw(cmd_rnw), .cmd_ext(cmd_ext),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_req(wr_req), .wr_data(wr_data),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .status(status), .status_valid(status_valid),
        .done(done), .busy(busy),
        .spi_start(spi_start), .spi_stop(spi_stop),
        .spi_dout(spi_dout), .spi_busy(spi_busy),
        .spi_load_next(spi_load_next), .spi_din(spi_din)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    bit active = 0;
    int cnt = 0;
    int tail = 0;
    int k = 0;
    int stall = 0;
    bit pop_pend = 0;
    bit inj_idle = 0;
    bit inj_drain = 0;
    int sv_cnt, rv_cnt, done_cnt, wr_cnt, lag_err, rdy_busy_cnt;
    int last_ln_cyc, stop_ln_cyc, done_cyc, sv_cyc;
    logic [7:0] st_seen;
    logic [7:0] mosi_log[$];
    logic [7:0] miso_q[$];
    logic [7:0] wq[$];
    logic [7:0] rd_log[$];

    logic [7:0] exp_mosi[$];
    logic [7:0] exp_rd[$];
    logic [7:0] exp_status;
    int exp_wr;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Monitor first (DUT outputs settled), then drive the engine side.
    initial begin
        logic [7:0] tmp;
        spi_busy = 1'b0;
        spi_load_next = 1'b0;
        spi_din = 8'h00;
        wr_data = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (status_valid) begin
                sv_cnt++;
                sv_cyc = cyc;
                st_seen = status;
                if (cyc != last_ln_cyc + 1) lag_err++;
            end
            if (rd_valid) begin
                rv_cnt++;
                rd_log.push_back(rd_data);
                if (cyc != last_ln_cyc + 1) lag_err++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (cyc != last_ln_cyc + 1) lag_err++;
            end
            if (cmd_ready && spi_busy) rdy_busy_cnt++;
            if (pop_pend) begin
                pop_pend = 0;
                if (wq.size() > 0) tmp = wq.pop_front();
                wr_data = (wq.size() > 0) ? wq[0] : 8'($urandom);
            end
            if (wr_req) begin
                wr_cnt++;
                pop_pend = 1;
            end
            spi_load_next = 1'b0;
            if (!rstn) begin
                active = 0;
                tail = 0;
                spi_busy = 1'b0;
                pop_pend = 0;
            end else if (active) begin
                cnt--;
                if (cnt <= 0) begin
                    spi_load_next = 1'b1;
                    last_ln_cyc = cyc;
                    spi_din = (k < miso_q.size()) ? miso_q[k] : 8'hEE;
                    k++;
                    if (spi_stop || k > 70) begin
                        active = 0;
                        tail = 3;
                        stop_ln_cyc = cyc;
                    end else begin
                        mosi_log.push_back(spi_dout);
                        cnt = 16 + $urandom_range(0, 4);
                    end
                end
            end else if (tail > 0) begin
                if (inj_drain) begin
                    spi_load_next = 1'b1;
                    inj_drain = 0;
                end
                tail--;
                if (tail == 0) spi_busy = 1'b0;
            end else if (spi_start) begin
                active = 1;
                spi_busy = 1'b1;
                k = 0;
                mosi_log.push_back(spi_dout);
                cnt = 16 + stall;
            end else if (inj_idle) begin
                spi_load_next = 1'b1;
                inj_idle = 0;
            end
        end
    end

    task automatic clear_mon();
        sv_cnt = 0; rv_cnt = 0; done_cnt = 0; wr_cnt = 0;
        lag_err = 0; rdy_busy_cnt = 0;
        done_cyc = -1; stop_ln_cyc = -10; sv_cyc = -1;
        st_seen = 8'h00;
        mosi_log.delete();
        rd_log.delete();
    endtask

    // Expected frame built from the command rules: header, [ext addr], data.
    task automatic setup(input bit rnw, input bit ext,
                         input logic [7:0] addr, input logic [5:0] len,
                         input int stl);
        int leff;
        int total;
        logic [7:0] b;
        clear_mon();
        exp_mosi.delete();
        exp_rd.delete();
        wq.delete();
        miso_q.delete();
        leff = (ext && len == 0) ? 1 : int'(len);
        total = 1 + int'(ext) + leff;
        b = {rnw, (leff > 1), (ext ? 6'h2F : addr[5:0])};
        exp_mosi.push_back(b);
        if (ext) exp_mosi.push_back(addr);
        for (int i = 0; i < leff; i++) begin
            b = 8'($urandom);
            if (rnw) exp_mosi.push_back(8'h00);
            else begin
                exp_mosi.push_back(b);
                wq.push_back(b);
            end
        end
        for (int i = 0; i < total; i++) miso_q.push_back(8'($urandom));
        exp_status = miso_q[0];
        if (rnw)
            for (int i = 1 + int'(ext); i < total; i++)
                exp_rd.push_back(miso_q[i]);
        exp_wr = rnw ? 0 : leff;
        wr_data = (wq.size() > 0) ? wq[0] : 8'($urandom);
        stall = stl;
        cmd_rnw = rnw;
        cmd_ext = ext;
        cmd_addr = addr;
        cmd_len = len;
        cmd_valid = 1'b1;
    endtask

    task automatic wait_accept(input string tag);
        int n = 0;
        while (!cmd_ready && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_accept"}, 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        chk({tag, "_start"}, 32'(spi_start), 1);
        chk({tag, "_busy"}, 32'(busy), 1);
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!(done_cnt > 0 && cmd_ready) && n < 3000) begin
            tick();
            n++;
        end
        chk({tag, "_end"}, 32'(n < 3000), 1);
        chk({tag, "_nbytes"}, mosi_log.size(), exp_mosi.size());
        for (int i = 0; i < exp_mosi.size() && i < mosi_log.size(); i++)
            chk($sformatf("%s_mosi%0d", tag, i), mosi_log[i], exp_mosi[i]);
        chk({tag, "_svcnt"}, sv_cnt, 1);
        chk({tag, "_status"}, st_seen, exp_status);
        chk({tag, "_rvcnt"}, rv_cnt, exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
            chk($sformatf("%s_rd%0d", tag, i), rd_log[i], exp_rd[i]);
        chk({tag, "_donecnt"}, done_cnt, 1);
        chk({tag, "_donelag"}, done_cyc, stop_ln_cyc + 1);
        chk({tag, "_wrcnt"}, wr_cnt, exp_wr);
        chk({tag, "_lag"}, lag_err, 0);
        chk({tag, "_rdybusy"}, rdy_busy_cnt, 0);
        chk({tag, "_doutz"}, spi_dout, 8'h00);
        chk({tag, "_stopz"}, 32'(spi_stop), 0);
        chk({tag, "_spibusy"}, 32'(spi_busy), 0);
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, 32'(cmd_ready), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_start"}, 32'(spi_start), 0);
        chk({tag, "_stop"}, 32'(spi_stop), 0);
        chk({tag, "_dout"}, spi_dout, 0);
        chk({tag, "_status"}, status, 0);
        chk({tag, "_pulses"},
            {wr_req, rd_valid, status_valid, done}, 0);
        chk({tag, "_rdata"}, rd_data, 0);
    endtask

    initial begin
        bit r;
        bit e;
        clear_mon();
        last_ln_cyc = -10;
        repeat (3) tick();
        chk_reset_outs("rst");
        rstn = 1'b1;
        chk("rst_rel_ready", 32'(cmd_ready), 0);
        tick();
        chk("rst_ready1", 32'(cmd_ready), 1);

        // single write
        setup(0, 0, 8'h01, 6'd1, 3);
        wq = '{8'h5A};
        wr_data = 8'h5A;
        exp_mosi = '{8'h01, 8'h5A};
        wait_accept("wr1");
        wait_end("wr1");

        // burst read with fixed MISO bytes
        setup(1, 0, 8'h10, 6'd3, 7);
        miso_q = '{8'h0F, 8'h11, 8'h22, 8'h33};
        exp_status = 8'h0F;
        exp_rd = '{8'h11, 8'h22, 8'h33};
        exp_mosi = '{8'hD0, 8'h00, 8'h00, 8'h00};
        wait_accept("brd");
        wait_end("brd");

        // extended read
        setup(1, 1, 8'h8F, 6'd1, 0);
        exp_mosi = '{8'hAF, 8'h8F, 8'h00};
        wait_accept("xrd");
        wait_end("xrd");

        // strobe: single header byte, stop from the first byte
        setup(0, 0, 8'h30, 6'd0, 2);
        exp_mosi = '{8'h30};
        wait_accept("sres");
        tick();
        chk("sres_stop", 32'(spi_stop), 1);
        chk("sres_dout", spi_dout, 8'h30);
        wait_end("sres");
        chk("sres_sv_done", sv_cyc, done_cyc);

        // command held pending across a busy frame
        setup(0, 1, 8'h12, 6'd2, 1);
        wait_accept("ovA");
        repeat (3) tick();
        cmd_rnw = 1'b1;
        cmd_ext = 1'b0;
        cmd_addr = 8'h05;
        cmd_len = 6'd2;
        cmd_valid = 1'b1;
        chk("ov_notready", 32'(cmd_ready), 0);
        wait_end("ovA");
        setup(1, 0, 8'h05, 6'd2, 4);
        wait_accept("ovB");
        wait_end("ovB");

        // spurious load_next while idle
        clear_mon();
        inj_idle = 1;
        repeat (4) tick();
        chk("idle_inj_pulses", sv_cnt + rv_cnt + done_cnt, 0);
        chk("idle_inj_ready", 32'(cmd_ready), 1);

        // reset during the data byte of a write
        setup(0, 0, 8'h07, 6'd2, 0);
        wait_accept("rstw");
        begin
            int n = 0;
            while (mosi_log.size() < 2 && n < 300) begin
                tick();
                n++;
            end
            chk("rstw_reach", 32'(n < 300), 1);
        end
        tick();
        rstn = 1'b0;
        tick();
        chk_reset_outs("rstw");
        rstn = 1'b1;
        repeat (2) tick();
        chk("rstw_nodone", done_cnt, 0);
        chk("rstw_ready", 32'(cmd_ready), 1);
        setup(0, 0, 8'h07, 6'd2, 5);
        wait_accept("post");
        wait_end("post");

        // random frames
        for (int t = 0; t < 24; t++) begin
            r = 1'($urandom);
            e = 1'($urandom);
            setup(r, e, 8'($urandom), 6'($urandom_range(0, 6)),
                  $urandom_range(0, 10));
            inj_drain = 1'($urandom);
            wait_accept($sformatf("rnd%0d", t));
            wait_end($sformatf("rnd%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cc1200_reg_ctrl.md
# cc1200_reg_ctrl

Command sequencer in front of the CC1200 SPI byte engine. It turns one register-access command into a complete CS_n frame: header byte, optional extended-address byte, then 0..63 data bytes. It drives the engine's start/stop/data-out handshake, pulls write bytes from a source, and returns the chip status byte plus read bytes. It sits between the radio configuration/FIFO logic and the byte engine, and is the only master of that engine.

## Interface
- No parameters.
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request; held until accepted
- cmd_ready  out  1  high in IDLE only; accept = cmd_valid & cmd_ready
- cmd_rnw  in  1  1 = read, 0 = write
- cmd_ext  in  1  extended register space (0x2F prefix)
- cmd_addr  in  8  normal: [5:0] used; ext: full 8-bit extended address
- cmd_len  in  6  data byte count; 0 = strobe/header only
- wr_req  out  1  one-cycle pulse; wr_data sampled in the same cycle
- wr_data  in  8  next write byte; must be valid whenever wr_req pulses
- rd_data  out  8  read byte, registered
- rd_valid  out  1  one-cycle pulse per read byte
- status  out  8  chip status byte (first byte received in frame)
- status_valid  out  1  one-cycle pulse
- done  out  1  one-cycle pulse when the last byte is captured
- busy  out  1  high from accept until return to IDLE
- spi_start  out  1  one-cycle pulse to the engine
- spi_stop  out  1  level: byte in flight is the last in the frame
- spi_dout  out  8  byte presented to the engine
- spi_busy  in  1  engine busy
- spi_load_next  in  1  engine pulse at end of each byte; engine loads spi_dout here
- spi_din  in  8  engine receive register

## Operation
- Latched on accept: rnw, ext, addr, len. If ext and len = 0, len is forced to 1.
- Header: {rnw, len>1, addr[5:0]} when normal; {rnw, len>1, 6'h2F} when ext.
- Byte list: header, [addr when ext], len data bytes. total = 1 + ext + len.
- Data bytes: reads send 0x00. Writes send wr_data, pulling one wr_req per byte.
- States:
  - IDLE: accept loads spi_dout = header, then goes to START.
  - START: spi_start = 1 for exactly one cycle, then goes to XFER.
  - XFER: the cycle after spi_start or after any spi_load_next, spi_dout is updated to the next byte in the list. After the last byte, spi_dout = 0x00. The wr_req pulse occurs in that same update cycle.
  - DRAIN: waits for spi_busy = 0, then goes to IDLE.
- sent counter (7 bit): set to 1 at start, incremented at each spi_load_next. spi_stop = (sent == total) while in XFER, so the engine closes CS_n at the final load_next.
- Capture: the cycle after each spi_load_next, spi_din is sampled and handled by byte index.
  - Index 0: status, with status_valid.
  - Ext address byte: discarded.
  - Data bytes: rd_data/rd_valid on reads; discarded on writes.
- After the capture of byte total-1: done pulses and the state moves to DRAIN.

## Timing
- Reset values: all outputs 0, spi_dout = 0x00, status = 0x00, state IDLE. cmd_ready is 1 one cycle after reset release.
- Accept at cycle T gives spi_start at T+1. The first spi_load_next depends on the engine, which stalls until the chip is ready.
- spi_dout is stable at least one cycle before every spi_load_next, given the engine byte time of 16 or more cycles.
- rd_valid/status_valid/done lag the matching spi_load_next by exactly 1 cycle. done coincides with the final capture pulse.
- cmd_valid during busy is ignored; the request stays pending and is accepted in the first IDLE cycle.
- Extra spi_load_next in DRAIN or IDLE is ignored and causes no pulses.
- rstn assertion mid-frame: immediate IDLE, spi_start/spi_stop = 0, no done. The engine is reset on the same rstn.

## Test plan
- Write addr 0x01, len 1, wr_data 0x5A: spi_dout sequence 0x01, 0x5A. One wr_req. spi_stop high during byte 2. status_valid once, done once, no rd_valid.
- Burst read addr 0x10, len 3, MISO bytes 0x0F,0x11,0x22,0x33: header 0xD0. status = 0x0F. rd_data 0x11, 0x22, 0x33 with 3 rd_valid pulses. done on the third.
- Extended read addr 0x8F, len 1: spi_dout 0xAF, 0x8F, 0x00. spi_stop only on the third byte. One rd_valid.
- Strobe 0x30 (SRES), len 0: a single byte 0x30 with spi_stop high from the start. status_valid and done both occur 1 cycle after the first spi_load_next.
- cmd_valid held high during a frame with a second command: accepted only after spi_busy falls, with cmd_ready = 1. The second spi_start follows.
- rstn pulse during the data byte of a write: all outputs return to their reset values, no done. A subsequent command completes normally.
